// File: rtl/tt_um_emern_spi_host.sv
// tt_um_emern_spi_host: SPI mode 0 host that streams command bytes into a frame gated by a synchronized INT line.
// Define SPI_HOST_RSP_EN to build the MISO capture path (rsp_byte/rsp_valid); otherwise they are tied to 0.
module tt_um_emern_spi_host #(
  parameter int CLK_DIV = 1,
  parameter int CS_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_last,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_byte,
  output logic       rsp_valid,
  output logic       busy,
  input  logic       int_in,
  output logic       cs_n,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);
  localparam logic [2:0] IDLE = 3'd0, WAIT_INT = 3'd1, SETUP = 3'd2, SHIFT = 3'd3, NEXT = 3'd4, HOLD = 3'd5;
  logic [2:0] state, bcnt;
  logic [1:0] sync;
  logic [7:0] sr, div, hcnt;
  logic       last, ph, div_end, byte_end;
  assign div_end = div == CLK_DIV[7:0];
  assign byte_end = state == SHIFT && div_end && ph && bcnt == 3'd7;
  assign cmd_ready = !rst && (state == IDLE || state == NEXT);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sync <= 2'b00;
      sr <= 8'd0;
      div <= 8'd0;
      hcnt <= 8'd0;
      bcnt <= 3'd0;
      last <= 1'b0;
      ph <= 1'b0;
      cs_n <= 1'b1;
      sck <= 1'b0;
      mosi <= 1'b0;
    end else begin
      sync <= {sync[0], int_in};
      case (state)
        IDLE: if (cmd_valid) begin
          sr <= cmd_byte;
          last <= cmd_last;
          state <= WAIT_INT;
        end
        WAIT_INT: if (sync[1]) begin
          cs_n <= 1'b0;
          mosi <= sr[7];
          div <= 8'd0;
          state <= SETUP;
        end
        SETUP: if (div_end) begin
          div <= 8'd0;
          ph <= 1'b0;
          bcnt <= 3'd0;
          state <= SHIFT;
        end else div <= div + 8'd1;
        SHIFT: if (!div_end) div <= div + 8'd1;
        else begin
          div <= 8'd0;
          ph <= !ph;
          sck <= !ph;
          // ph high means this edge ends the high half-period and lowers sck
          if (ph && bcnt == 3'd7) begin
            hcnt <= 8'd0;
            state <= last ? HOLD : NEXT;
          end else if (ph) begin
            bcnt <= bcnt + 3'd1;
            sr <= {sr[6:0], 1'b0};
            mosi <= sr[6];
          end
        end
        NEXT: if (cmd_valid) begin
          sr <= cmd_byte;
          last <= cmd_last;
          mosi <= cmd_byte[7];
          div <= 8'd0;
          ph <= 1'b0;
          bcnt <= 3'd0;
          state <= SHIFT;
        end
        HOLD: begin
          cs_n <= 1'b1;
          state <= hcnt == CS_HOLD[7:0] ? IDLE : HOLD;
          hcnt <= hcnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SPI_HOST_RSP_EN
  logic [7:0] rx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx <= 8'd0;
      rsp_byte <= 8'd0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= byte_end;
      if (state == SHIFT && div_end && !ph) rx <= {rx[6:0], miso};
      if (byte_end) rsp_byte <= rx;
    end
  end
`else
  logic unused_rsp;
  assign unused_rsp = miso ^ byte_end;
  assign rsp_byte = 8'd0;
  assign rsp_valid = 1'b0;
`endif
endmodule

// File: tb/tb_tt_um_emern_spi_host.sv
// tb_tt_um_emern_spi_host: random frames checked by an SPI-pin monitor against queued bytes and timing rules.
module tb_tt_um_emern_spi_host;
  localparam int CLK_DIV = 1;
  localparam int CS_HOLD = 4;
  localparam int H = CLK_DIV + 1;
  localparam int LIM = 2000;
  logic clk = 1'b0;
  logic rst, cmd_last, cmd_valid, cmd_ready, rsp_valid, busy, int_in, cs_n, sck, mosi, miso, mrand;
  logic [7:0] cmd_byte, rsp_byte;
  int checks = 0, failures = 0;
  int mm, exp_len, nb, lowc, highc, frame_bytes, bytes_total;
  logic prev_sck, prev_cs, first, done_pending, byte_done, rv_seen;
  logic [7:0] shm, shs;
  logic [7:0] fb [8];
  logic [7:0] tx_q [$];
  logic [7:0] rsp_q [$];

  tt_um_emern_spi_host #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .rst(rst), .cmd_byte(cmd_byte), .cmd_last(cmd_last), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .rsp_byte(rsp_byte), .rsp_valid(rsp_valid), .busy(busy),
    .int_in(int_in), .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;
  assign miso = mm == 2 ? mosi : mm == 1 ? 1'b1 : mrand;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      nb = 0; lowc = 0; highc = 0; first = 0; done_pending = 0;
      prev_sck = 0; prev_cs = 1;
      tx_q.delete(); rsp_q.delete();
    end else begin
      byte_done = 0;
      if (!cs_n && prev_cs) begin lowc = 0; first = 1; frame_bytes = 0; end
      if (sck && !prev_sck) begin
        check("sck_with_cs", cs_n, 0);
        if (first) check("setup_low", lowc, 2 * H);
        else if (nb != 0) check("low_width", lowc, H);
        first = 0; lowc = 0;
        shm = {shm[6:0], mosi};
        shs = {shs[6:0], miso};
        nb++;
        if (nb == 8) begin
          nb = 0; done_pending = 1; frame_bytes++; bytes_total++;
          if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
          else check("mosi_byte", shm, tx_q.pop_front());
`ifdef SPI_HOST_RSP_EN
          rsp_q.push_back(shs);
`endif
        end
      end
      if (!sck && prev_sck) begin
        check("high_width", highc, H);
        highc = 0;
        byte_done = done_pending;
        done_pending = 0;
      end
      if (sck) highc++; else lowc++;
      if (cs_n && !prev_cs) begin
        check("frame_len", frame_bytes, exp_len);
        check("cs_mid_byte", nb, 0);
      end
`ifdef SPI_HOST_RSP_EN
      if (rsp_valid || byte_done) begin
        check("rsp_strobe", rsp_valid, byte_done);
        if (rsp_valid && byte_done && rsp_q.size() != 0) check("rsp_byte", rsp_byte, rsp_q.pop_front());
      end
`else
      if (byte_done) check("rsp_off", {rsp_valid, rsp_byte}, 0);
`endif
      if (rsp_valid) rv_seen = 1;
      prev_sck = sck;
      prev_cs = cs_n;
      mrand = 1'($urandom);
    end
  end

  task automatic wait_ready();
    int cnt = 0;
    while (!cmd_ready && cnt < LIM) begin @(negedge clk); cnt++; end
    if (cnt >= LIM) check("ready_timeout", 0, 1);
  endtask

  // imode: 0 int held high, 1 int low until 20 cycles after the first accept, 2 int dropped once cs_n falls
  task automatic send_frame(input int n, input int imode, input int stall_at, input int stall_len);
    int base, cnt;
    base = bytes_total;
    exp_len = n;
    int_in = imode != 1;
    if (imode == 1) repeat (3) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && i == stall_at) begin
        wait_ready();
        repeat (stall_len) begin
          @(negedge clk);
          check("stall_pins", {cs_n, sck}, 2'b00);
        end
      end
      cmd_byte = fb[i];
      cmd_last = i == n - 1;
      cmd_valid = 1;
      wait_ready();
      tx_q.push_back(fb[i]);
      @(negedge clk);
      cmd_valid = 0;
      if (i == 0 && imode == 1) begin
        repeat (20) begin
          check("cs_before_int", cs_n, 1);
          @(negedge clk);
        end
        int_in = 1;
        cnt = 0;
        while (cs_n && cnt < 50) begin @(negedge clk); cnt++; end
        check("int_latency", cnt, 3);
      end
      if (i == 0 && imode == 2) begin
        cnt = 0;
        while (cs_n && cnt < LIM) begin @(negedge clk); cnt++; end
        check("cs_fall_seen", cnt < LIM, 1);
        int_in = 0;
      end
    end
    cnt = 0;
    while (!(bytes_total == base + n && cs_n) && cnt < LIM) begin @(negedge clk); cnt++; end
    check("frame_done", cnt < LIM, 1);
    cnt = 0;
    while (!cmd_ready && cnt < LIM) begin
      check("hold_busy", {busy, cs_n}, 2'b11);
      cnt++;
      @(negedge clk);
    end
    check("cs_hold", cnt, CS_HOLD);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int cnt;
    rst = 1; cmd_valid = 0; cmd_last = 0; cmd_byte = 0; int_in = 0;
    mm = 0; mrand = 0; exp_len = 0; bytes_total = 0; rv_seen = 0; shm = 0; shs = 0; frame_bytes = 0;
    #1;
    check("rst_pins", {cs_n, sck, mosi}, 3'b100);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp", {rsp_valid, rsp_byte}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1 check("rel_ready", cmd_ready, 1);
    @(negedge clk);
    mm = 1; fb[0] = 8'hA5;
    send_frame(1, 0, 9, 0);
    mm = 0; fb[0] = 8'h3C;
    send_frame(1, 1, 9, 0);
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    send_frame(3, 0, 1, 10);
    int_in = 1; cmd_byte = 8'h81; cmd_last = 1; cmd_valid = 1; exp_len = 1;
    wait_ready();
    tx_q.push_back(8'h81);
    @(negedge clk);
    cmd_valid = 0;
    cnt = 0;
    while (nb != 4 && cnt < LIM) begin @(negedge clk); cnt++; end
    check("bit4_reached", cnt < LIM, 1);
    #2 rst = 1;
    #1;
    check("abort_pins", {cs_n, sck, mosi}, 3'b100);
    check("abort_ready", {cmd_ready, busy, rsp_valid}, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    #1 check("abort_rel_ready", cmd_ready, 1);
    @(negedge clk);
    mm = 2; fb[0] = 8'h5A; fb[1] = 8'hC3;
    send_frame(2, 0, 9, 0);
    mm = 0; fb[0] = 8'h96; fb[1] = 8'h0F;
    send_frame(2, 2, 9, 0);
    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
      mm = $urandom_range(0, 2);
      send_frame(n, $urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(0, 6));
    end
    repeat (5) @(negedge clk);
    check("tx_drained", tx_q.size(), 0);
`ifdef SPI_HOST_RSP_EN
    check("rsp_drained", rsp_q.size(), 0);
`else
    check("rsp_never", rv_seen, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_um_emern_spi_host.md
TT_UM_EMERN_SPI_HOST -- requirements
Module: tt_um_emern_spi_host

Interface
REQ-001 Parameter CLK_DIV, default 1: SCK half-period is CLK_DIV+1 clk cycles; legal range 0..255.
REQ-002 Parameter CS_HOLD, default 4: minimum clk cycles CS stays high between frames; legal range 1..255.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_byte  in  8  next byte to transmit, MSB first.
REQ-006 cmd_last  in  1  qualifies cmd_byte as the final byte of the frame.
REQ-007 cmd_valid  in  1  cmd_byte/cmd_last valid.
REQ-008 cmd_ready  out  1  byte accepted on a clk edge where cmd_valid and cmd_ready are both high.
REQ-009 rsp_byte  out  8  byte shifted in on MISO during the preceding transmitted byte.
REQ-010 rsp_valid  out  1  one-cycle strobe qualifying rsp_byte.
REQ-011 busy  out  1  high from frame acceptance until CS_HOLD expires.
REQ-012 int_in  in  1  GPU INT (high = load window open); asynchronous to clk.
REQ-013 cs_n, sck, mosi  out  1 each  SPI mode 0 master pins; miso  in  1.

Function
REQ-014 int_in SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-015 FSM states: IDLE, WAIT_INT, SETUP, SHIFT, NEXT, HOLD.
REQ-016 IDLE: cmd_ready=1; on handshake latch byte/last into shift register, go WAIT_INT.
REQ-017 WAIT_INT: cmd_ready=0, cs_n=1; on synchronized int high go SETUP, driving cs_n=0 and mosi=bit7 that cycle.
REQ-018 SETUP: hold sck=0 for one half-period, then SHIFT.
REQ-019 SHIFT: 8 bits; each bit sck low one half-period then high one half-period; miso sampled on the clk edge that raises sck; mosi updated on the edge that lowers sck.
REQ-020 After the 8th high half-period, sck returns low; rsp_byte updated and rsp_valid pulsed for exactly one cycle.
REQ-021 If latched byte was not last: go NEXT, cmd_ready=1; on handshake load byte, present bit7 on mosi, enter SHIFT with no extra SETUP; while cmd_valid=0 stall with cs_n=0, sck=0.
REQ-022 If latched byte was last: cs_n=1 on the cycle after the final sck fall, go HOLD for CS_HOLD cycles, then IDLE.
REQ-023 Once cs_n falls the frame SHALL complete regardless of int_in deassertion.
REQ-024 cmd_ready SHALL be 0 in WAIT_INT, SETUP, SHIFT, HOLD.
REQ-025 Bit and divider counters SHALL wrap only via explicit reload; no frame-length limit.

Reset
REQ-026 rst SHALL asynchronously force IDLE, cs_n=1, sck=0, mosi=0, cmd_ready=0 while asserted, rsp_valid=0, rsp_byte=0, busy=0, synchronizer flops 0.
REQ-027 Reset mid-frame SHALL abort immediately with cs_n=1; the partial byte is discarded; cmd_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-028 Macro SPI_HOST_RSP_EN defined: MISO capture, rsp_byte and rsp_valid behave per REQ-019/020.
REQ-029 SPI_HOST_RSP_EN undefined: capture logic removed; rsp_byte=0 and rsp_valid=0 constantly; all other timing identical.

Verification
REQ-030 CLK_DIV=1, int_in=1, one byte 0xA5 last=1, miso tied 1 -> mosi 1,0,1,0,0,1,0,1 at sck rises, 8 sck pulses each 2 clk high/2 low, rsp_byte=0xFF one-cycle rsp_valid, cs_n high 4 cycles before cmd_ready.
REQ-031 int_in=0 during accept of 0x3C, raise after 20 cycles -> cs_n stays 1 until 2 sync cycles after rise, then frame proceeds.
REQ-032 Three-byte frame 0x01,0x02,0x03 with cmd_valid dropped 10 cycles before byte 2 -> cs_n continuously low, sck low during stall, 24 sck pulses total.
REQ-033 Assert rst during bit 4 of byte 0x81 -> cs_n=1, sck=0 same cycle asynchronously, no rsp_valid.
REQ-034 Loopback miso=mosi, frame 0x5A,0xC3 -> rsp_byte 0x5A then 0xC3 with SPI_HOST_RSP_EN; rsp_valid never high without it.
REQ-035 int_in dropped after cs_n falls on 2-byte frame -> both bytes transmitted, cs_n rises only after last byte.
